// File: rtl/uds_rdonce_ctrl.sv
// uds_rdonce_ctrl: read-once secret store controller.
// Sits between the bus decoder and a synchronous secret ROM. Each secret
// word is handed out at most once per reset, and only while app_mode is low.
// Read data is scrubbed to zero outside the single response cycle.
// A status bank (address MSB = 1) exposes the all-read, lock and app-seen
// flags and the read mask.
// Optional build macro UDS_DENY_CNT_EN: adds an 8-bit saturating counter of
// refused secret-bank accesses, readable at status index 2.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for cs; grants a ROM fetch or loads status/zero response
// FETCH  | ROM word arriving this cycle; captured (or zeroed) into resp_q
// RESP   | ready=1, read_data=resp_q; resp_q cleared on the way out

module uds_rdonce_ctrl #(
    parameter int NUM_WORDS  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  app_mode,
    input  logic                  cs,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  rom_re,
    output logic [ADDR_WIDTH-2:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  locked
);

    localparam int IDX_W = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [NUM_WORDS-1:0]  rd_mask;
    logic [NUM_WORDS-1:0]  idx_onehot;
    logic                  app_seen;
    logic                  all_read;
    logic                  lock;
    logic [DATA_WIDTH-1:0] resp_q;
    logic [DATA_WIDTH-1:0] status_val;

    logic                  bank_status;
    logic [IDX_W-1:0]      index;
    logic [31:0]           index_ext;
    logic                  idx_valid;
    logic                  word_read;
    logic                  accept;
    logic                  grant;

    assign bank_status = address[ADDR_WIDTH-1];
    assign index       = address[IDX_W-1:0];
    assign index_ext   = 32'(index);
    assign idx_valid   = index_ext < 32'(NUM_WORDS);

    // Lock is derived from registered flags only, so it trails a grant or an
    // app_mode cycle by one clock.
    assign all_read = &rd_mask;
    assign lock     = app_seen | all_read;
    assign locked   = lock;

    // One-hot decode of the index; stays zero for indices beyond NUM_WORDS.
    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (index_ext == 32'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign word_read = |(rd_mask & idx_onehot);
    assign accept    = (state == ST_IDLE) && cs;
    assign grant     = accept && !bank_status && idx_valid && !lock &&
                       !app_mode && !word_read;

`ifdef UDS_DENY_CNT_EN
    logic [7:0] deny_cnt;

    // Count refused secret-bank accesses, saturating at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deny_cnt <= 8'd0;
        end else if (accept && !bank_status && !grant && (deny_cnt != 8'hFF)) begin
            deny_cnt <= deny_cnt + 8'd1;
        end
    end
`endif

    // Status bank read mux.
    always_comb begin
        status_val = '0;
        case (index_ext)
            32'd0:   status_val = DATA_WIDTH'({app_seen, lock, all_read});
            32'd1:   status_val = DATA_WIDTH'(rd_mask);
`ifdef UDS_DENY_CNT_EN
            32'd2:   status_val = DATA_WIDTH'(deny_cnt);
`endif
            default: status_val = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; cs is ignored once a transaction has started.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_FETCH;
                end else if (accept) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_FETCH: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; read_data is forced to zero outside RESP.
    always_comb begin
        ready     = (state == ST_RESP);
        read_data = (state == ST_RESP) ? resp_q : '0;
        rom_re    = grant;
        rom_addr  = grant ? index : '0;
    end

    // Response register: loaded on acceptance or ROM capture, cleared after RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        resp_q <= bank_status ? status_val : '0;
                    end
                end
                ST_FETCH: resp_q <= app_mode ? '0 : rom_data;
                ST_RESP:  resp_q <= '0;
                default:  resp_q <= '0;
            endcase
        end
    end

    // Sticky read mask and app-mode history; the mask bit survives an
    // app_mode abort during FETCH so the word stays consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_mask  <= '0;
            app_seen <= 1'b0;
        end else begin
            if (grant) begin
                rd_mask <= rd_mask | idx_onehot;
            end
            if (app_mode) begin
                app_seen <= 1'b1;
            end
        end
    end

endmodule
